// File: rtl/sbox_sched_if.sv
// Bundle of request/result handshakes between the round controller, the key
// schedule and the S-box scheduler, plus the link to the shared S-box slice.
// The slave side is the scheduler; the master side drives requests, accepts
// results and plays the combinational S-box slice.
interface sbox_sched_if;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_data;
  logic         st_out_valid;
  logic         st_out_ready;
  logic [127:0] st_out;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw_data;
  logic         kw_out_valid;
  logic         kw_out_ready;
  logic [31:0]  kw_out;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic         busy;

  modport master (
    output st_valid, st_data, st_out_ready,
    output kw_valid, kw_data, kw_out_ready,
    output sb_out,
    input  st_ready, st_out_valid, st_out,
    input  kw_ready, kw_out_valid, kw_out,
    input  sb_in, busy
  );

  modport slave (
    input  st_valid, st_data, st_out_ready,
    input  kw_valid, kw_data, kw_out_ready,
    input  sb_out,
    output st_ready, st_out_valid, st_out,
    output kw_ready, kw_out_valid, kw_out,
    output sb_in, busy
  );
endinterface

// File: rtl/sbox_sched.sv
// Time-shares one 32-bit S-box slice between a 128-bit state SubBytes job
// (four beats, word 0 = most significant) and a 32-bit key SubWord job (one
// beat). Each side owns a buffer that is substituted in place and held until
// its consumer takes the result. ARB_MODE 0 gives the key priority on a
// conflict; ARB_MODE 1 alternates between the two on successive conflicts.
module sbox_sched #(
  parameter int unsigned ARB_MODE = 0
) (
  input logic          clk,
  input logic          rst_n,
  sbox_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } st_state_e;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_WAIT = 2'd1,
    K_DONE = 2'd2
  } kw_state_e;

  st_state_e    st_state_q, st_state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] st_buf_q, st_buf_d;
  kw_state_e    kw_state_q, kw_state_d;
  logic [31:0]  kw_buf_q, kw_buf_d;
  logic         rr_key_q, rr_key_d;

  logic         st_work;
  logic         kw_work;
  logic         conflict;
  logic         grant_st;
  logic         grant_kw;
  logic [31:0]  st_word;

  // Arbitration: whichever side still has a beat to run; on a conflict the
  // policy decides, and the round-robin pointer names the side owed the slot.
  always_comb begin
    st_work  = (st_state_q == S_RUN);
    kw_work  = (kw_state_q == K_WAIT);
    conflict = st_work && kw_work;
    grant_kw = kw_work && (!st_work || (ARB_MODE == 0) || rr_key_q);
    grant_st = st_work && !grant_kw;
  end

  // Select the state word for the current beat, most significant word first.
  always_comb begin
    st_word = st_buf_q[127:96];
    case (beat_q)
      2'd0: st_word = st_buf_q[127:96];
      2'd1: st_word = st_buf_q[95:64];
      2'd2: st_word = st_buf_q[63:32];
      2'd3: st_word = st_buf_q[31:0];
      default: st_word = st_buf_q[127:96];
    endcase
  end

  // State side: capture, four granted beats written back in place, then hold
  // the result until the consumer takes it.
  always_comb begin
    st_state_d = st_state_q;
    beat_d     = beat_q;
    st_buf_d   = st_buf_q;
    case (st_state_q)
      S_IDLE: begin
        if (bus.st_valid) begin
          st_buf_d   = bus.st_data;
          beat_d     = 2'd0;
          st_state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (grant_st) begin
          case (beat_q)
            2'd0: st_buf_d[127:96] = bus.sb_out;
            2'd1: st_buf_d[95:64]  = bus.sb_out;
            2'd2: st_buf_d[63:32]  = bus.sb_out;
            2'd3: st_buf_d[31:0]   = bus.sb_out;
            default: st_buf_d = st_buf_q;
          endcase
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            st_state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.st_out_ready) begin
          st_state_d = S_IDLE;
        end
      end
      default: begin
        st_state_d = S_IDLE;
      end
    endcase
  end

  // Key side: capture, one granted beat written back in place, then hold.
  always_comb begin
    kw_state_d = kw_state_q;
    kw_buf_d   = kw_buf_q;
    case (kw_state_q)
      K_IDLE: begin
        if (bus.kw_valid) begin
          kw_buf_d   = bus.kw_data;
          kw_state_d = K_WAIT;
        end
      end
      K_WAIT: begin
        if (grant_kw) begin
          kw_buf_d   = bus.sb_out;
          kw_state_d = K_DONE;
        end
      end
      K_DONE: begin
        if (bus.kw_out_ready) begin
          kw_state_d = K_IDLE;
        end
      end
      default: begin
        kw_state_d = K_IDLE;
      end
    endcase
  end

  // Round-robin pointer moves only when both sides actually competed.
  always_comb begin
    rr_key_d = rr_key_q;
    if ((ARB_MODE == 1) && conflict) begin
      rr_key_d = grant_st;
    end
  end

  // State-side registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_state_q <= S_IDLE;
      beat_q     <= 2'd0;
      st_buf_q   <= '0;
    end else begin
      st_state_q <= st_state_d;
      beat_q     <= beat_d;
      st_buf_q   <= st_buf_d;
    end
  end

  // Key-side registers and arbitration pointer (pointer starts on state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kw_state_q <= K_IDLE;
      kw_buf_q   <= '0;
      rr_key_q   <= 1'b0;
    end else begin
      kw_state_q <= kw_state_d;
      kw_buf_q   <= kw_buf_d;
      rr_key_q   <= rr_key_d;
    end
  end

  // Results are only exposed once complete, so partial words never leak out.
  assign bus.st_ready     = (st_state_q == S_IDLE);
  assign bus.st_out_valid = (st_state_q == S_DONE);
  assign bus.st_out       = (st_state_q == S_DONE) ? st_buf_q : '0;
  assign bus.kw_ready     = (kw_state_q == K_IDLE);
  assign bus.kw_out_valid = (kw_state_q == K_DONE);
  assign bus.kw_out       = (kw_state_q == K_DONE) ? kw_buf_q : '0;
  assign bus.sb_in        = grant_st ? st_word : (grant_kw ? kw_buf_q : '0);
  assign bus.busy         = (st_state_q != S_IDLE) || (kw_state_q != K_IDLE);

endmodule
